multi_pilot_tone_generator: RTL and testbench

//  Multi-channel pilot-tone reference generator in the EVR clock domain. Each

---
 rtl/multi_pilot_tone_generator.sv | 108 ++++++++++
 tb/tb_multi_pilot_tone_generator.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/multi_pilot_tone_generator.sv
// multi_pilot_tone_generator: sync-aligned, double-buffered multi-channel hi/lo pilot tone generator
//  evrClk/evrResetN : sole clock, async active-low reset
//  evrSync          : 1-cycle sync strobe, commits pending/armed/free-running channels
//  csrStrobe/csrAddr/csrWdata : shadow writes, csrAddr = {channel, word}
//  csrRdata         : registered readback (word0 ctrl, word1 status/phase)
//  pilotTone/running: registered per-channel tone and activity flags
module multi_pilot_tone_generator #(
  parameter int CHANNEL_COUNT  = 4,
  parameter int COUNTER_WIDTH  = 12,
  parameter int CHAN_SEL_WIDTH = 2
) (
  input  logic                      evrClk,
  input  logic                      evrResetN,
  input  logic                      evrSync,
  input  logic                      csrStrobe,
  input  logic [CHAN_SEL_WIDTH:0]   csrAddr,
  input  logic [31:0]               csrWdata,
  output logic [31:0]               csrRdata,
  output logic [CHANNEL_COUNT-1:0]  pilotTone,
  output logic [CHANNEL_COUNT-1:0]  running
);
  localparam int CW = COUNTER_WIDTH;
  localparam int CSW = CHAN_SEL_WIDTH;
  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} toneStateT;
  logic [CHANNEL_COUNT-1:0][31:0] ctrlWord;
  logic [CHANNEL_COUNT-1:0][31:0] statWord;
  logic [31:0] rdNext;
  genvar c;
  for (c = 0; c < CHANNEL_COUNT; c++) begin : gCh
    toneStateT state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [CW-1:0] shadowHi, shadowLo, shadowPh, activeHi, activeLo;
    logic shadowEn, shadowOs, activeOs, pending, armed, toneReg, runReg;
    logic wrHit, wrCtrl, wrPhase, disableWr, reload, cfgBad, toneNext, runNext;
    assign wrHit = csrStrobe && csrAddr[CSW:1] == CSW'(c);
    assign wrCtrl = wrHit && !csrAddr[0];
    assign wrPhase = wrHit && csrAddr[0];
    assign disableWr = wrCtrl && !csrWdata[31];
    // Reload uses the shadow as it stood before any same-cycle write
    assign reload = evrSync && (pending || (state != IDLE && !activeOs) || armed);
    assign cfgBad = !shadowEn || shadowHi == '0 || shadowLo == '0;
    always_ff @(posedge evrClk or negedge evrResetN)
      if (!evrResetN) begin
        state <= IDLE;
        cnt <= '0;
        toneReg <= 1'b0;
        runReg <= 1'b0;
      end else begin
        state <= stateNext;
        cnt <= cntNext;
        toneReg <= toneNext;
        runReg <= runNext;
      end
    always_comb begin
      stateNext = state;
      cntNext = state == IDLE ? cnt : cnt - CW'(1);
      if (disableWr) begin
        stateNext = IDLE;
        cntNext = '0;
      end else if (reload) begin
        stateNext = cfgBad ? IDLE : shadowPh == '0 ? HIGH : DELAY;
        cntNext = cfgBad ? '0 : shadowPh == '0 ? shadowHi - CW'(1) : shadowPh - CW'(1);
      end else if (state != IDLE && cnt == '0) begin
        stateNext = state == HIGH ? LOW : HIGH;
        cntNext = state == HIGH ? activeLo - CW'(1) : activeHi - CW'(1);
      end
    end
    // Disable forces the outputs low on the very next edge, skipping the pipeline stage
    always_comb begin
      toneNext = state == HIGH && !disableWr;
      runNext = state != IDLE && !disableWr;
    end
    always_ff @(posedge evrClk or negedge evrResetN)
      if (!evrResetN) begin
        {shadowEn, shadowOs, shadowHi, shadowLo, shadowPh} <= '0;
        {activeOs, activeHi, activeLo, pending, armed} <= '0;
      end else begin
        if (reload) begin
          activeOs <= shadowOs;
          activeHi <= shadowHi;
          activeLo <= shadowLo;
          pending <= 1'b0;
          armed <= 1'b0;
        end
        if (wrCtrl) begin
          shadowEn <= csrWdata[31];
          shadowOs <= csrWdata[30];
          shadowHi <= csrWdata[15 +: CW];
          shadowLo <= csrWdata[0 +: CW];
          if (csrWdata[30]) armed <= 1'b1;
        end
        if (wrPhase) shadowPh <= csrWdata[0 +: CW];
        if (wrHit) pending <= 1'b1;
      end
    assign ctrlWord[c] = {shadowEn, shadowOs, 15'(shadowHi), 15'(shadowLo)};
    assign statWord[c] = {pending, armed, runReg, 14'b0, 15'(shadowPh)};
    assign pilotTone[c] = toneReg;
    assign running[c] = runReg;
  end
  always_comb begin
    rdNext = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++)
      if (csrAddr[CSW:1] == CSW'(i)) rdNext = csrAddr[0] ? statWord[i] : ctrlWord[i];
  end
  always_ff @(posedge evrClk or negedge evrResetN)
    if (!evrResetN) csrRdata <= '0;
    else csrRdata <= rdNext;
endmodule

// File: tb/tb_multi_pilot_tone_generator.sv
// tb_multi_pilot_tone_generator: directed self-checking bench for multi_pilot_tone_generator
module tb_multi_pilot_tone_generator;
  logic evrClk = 1'b0;
  logic evrResetN = 1'b0;
  logic evrSync = 1'b0;
  logic csrStrobe = 1'b0;
  logic [2:0] csrAddr = '0;
  logic [31:0] csrWdata = '0;
  logic [31:0] csrRdata;
  logic [3:0] pilotTone, running;
  int passed = 0;
  int failed = 0;
  int total = 0;
  multi_pilot_tone_generator dut (
    .evrClk(evrClk), .evrResetN(evrResetN), .evrSync(evrSync),
    .csrStrobe(csrStrobe), .csrAddr(csrAddr), .csrWdata(csrWdata),
    .csrRdata(csrRdata), .pilotTone(pilotTone), .running(running)
  );
  always #5 evrClk = ~evrClk;
  task automatic tick();
    @(posedge evrClk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    csrStrobe = 1'b1;
    csrAddr = a;
    csrWdata = d;
    tick();
    csrStrobe = 1'b0;
  endtask
  task automatic sync();
    evrSync = 1'b1;
    tick();
    evrSync = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a);
    csrAddr = a;
    tick();
  endtask
  // tone level n edges after the sync edge for a hi/lo wave delayed by phase p
  function automatic logic e(int n, int hi, int lo, int p);
    return n >= p + 1 && ((n - p - 1) % (hi + lo)) < hi;
  endfunction
  initial begin
    tick();
    check("rst tone", 32'(pilotTone), 0);
    check("rst run", 32'(running), 0);
    check("rst rdata", csrRdata, 0);
    tick();
    evrResetN = 1'b1;
    tick();
    check("post-rst tone", 32'(pilotTone), 0);
    wr(3'd0, 32'h8001_8005);
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h8001_8005);
    wr(3'd3, 32'd4);
    wr(3'd4, 32'h8000_0005);
    rd(3'd0);
    check("ch0 ctrl", csrRdata, 32'h8001_8005);
    rd(3'd1);
    check("ch0 stat pre", csrRdata, 32'h8000_0000);
    rd(3'd3);
    check("ch1 stat pre", csrRdata, 32'h8000_0004);
    sync();
    check("n0 tone", 32'(pilotTone), 0);
    check("n0 run", 32'(running), 0);
    for (int n = 1; n <= 805; n++) begin
      tick();
      check($sformatf("t2 tone n=%0d", n), 32'(pilotTone), 32'({2'b00, e(n, 3, 5, 4), e(n, 3, 5, 0)}));
      check($sformatf("t2 run n=%0d", n), 32'(running), 32'h3);
    end
    rd(3'd1);
    check("ch0 pending clr", csrRdata, 32'h2000_0000);
    rd(3'd5);
    check("ch2 stat", csrRdata, 32'h0000_0000);
    wr(3'd6, 32'h8001_0002);
    wr(3'd7, 32'h0);
    sync();
    evrSync = 1'b1;
    csrStrobe = 1'b1;
    csrAddr = 3'd6;
    csrWdata = 32'h8000_8001;
    tick();
    evrSync = 1'b0;
    csrStrobe = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      check($sformatf("t4 old n=%0d", n), 32'(pilotTone[3]), 32'(e(n, 2, 2, 0)));
    end
    rd(3'd7);
    check("ch3 pending", csrRdata, 32'hA000_0000);
    sync();
    for (int n = 1; n <= 6; n++) begin
      tick();
      check($sformatf("t4 new n=%0d", n), 32'(pilotTone[3]), 32'(e(n, 1, 1, 0)));
    end
    rd(3'd7);
    check("ch3 pending clr", csrRdata, 32'h2000_0000);
    rd(3'd6);
    check("ch3 ctrl", csrRdata, 32'h8000_8001);
    wr(3'd0, 32'hC001_8005);
    rd(3'd1);
    check("ch0 armed", csrRdata, 32'hE000_0000);
    sync();
    for (int n = 1; n <= 60; n++) begin
      evrSync = n == 37;
      tick();
      check($sformatf("t5 os n=%0d", n), 32'(pilotTone[0]), 32'(e(n, 3, 5, 0)));
    end
    evrSync = 1'b0;
    rd(3'd1);
    check("ch0 disarmed", csrRdata, 32'h2000_0000);
    wr(3'd0, 32'hC001_8005);
    sync();
    for (int n = 1; n <= 16; n++) begin
      tick();
      check($sformatf("t5 rearm n=%0d", n), 32'(pilotTone[0]), 32'(e(n, 3, 5, 0)));
    end
    wr(3'd0, 32'h0001_8005);
    check("dis tone", 32'(pilotTone[0]), 0);
    check("dis run", 32'(running[0]), 0);
    tick();
    check("dis tone2", 32'(pilotTone[0]), 0);
    rd(3'd2);
    check("ch1 ctrl", csrRdata, 32'h8001_8005);
    check("pre-rst run", 32'(running), 32'hA);
    @(posedge evrClk);
    #3 evrResetN = 1'b0;
    #1;
    check("mid-rst tone", 32'(pilotTone), 0);
    check("mid-rst run", 32'(running), 0);
    check("mid-rst rdata", csrRdata, 0);
    tick();
    tick();
    evrResetN = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check($sformatf("post-rst tone %0d", n), 32'(pilotTone), 0);
    end
    check("post-rst rdata", csrRdata, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
